tdc_sample_accumulator: RTL

Downstream consumer of the inverter-chain delay sensor. Samples the sensor's asynchronous `delayed_clk` output on the rising edge of `clk` through a synchronizer and counts high samples and sample transitions over a power-of-two window. Publishes the counts as 8-bit results with a valid/ack handshake, giving a digital delay/jitter metric for the top level to drive onto `uo_out`.

---
 rtl/tdc_sample_accumulator.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/tdc_sample_accumulator.sv
// Purpose: synchronizes the sensor's delayed_clk and counts high samples and transitions over 2^WIN_LOG2 samples.
// Latency: result_valid rises SYNC_STAGES+2^WIN_LOG2+1 cycles after start is sampled.
// Backpressure: results are held in DONE until result_ack; start is ignored outside IDLE.
// Build option: define TDC_EDGE_COUNT_EN to build the transition counter (otherwise edge_count is tied to 0).
module tdc_sample_accumulator #(
  parameter int WIN_LOG2    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       delayed_clk,
  input  logic       start,
  input  logic       result_ack,
  output logic       busy,
  output logic       result_valid,
  output logic [7:0] ones_count,
  output logic [7:0] edge_count
);

  // Counters hold up to 2^WIN_LOG2 without wrapping.
  localparam int CW = WIN_LOG2 + 1;

  localparam logic [CW-1:0] WIN_LAST    = CW'((2 ** WIN_LOG2) - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SYNC_STAGES - 1);

  // LATCH is a one-cycle tail after the window: the last sample lands in the
  // counters at the final MEASURE edge, and the saturated copies are taken
  // from the counters on the following edge, which is the DONE entry edge.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_LATCH   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic [CW-1:0]          r_phase_cnt;
  logic [CW-1:0]          r_ones;
  logic                   r_busy;
  logic                   r_valid;
  logic [7:0]             r_ones_count;
  logic                   w_start_acc;

  // Clamp a counter value to the 8-bit result range.
  function automatic logic [7:0] sat8(input logic [CW-1:0] v);
    logic [31:0] wide;
    wide = 32'(v);
    if (wide > 32'd255) begin
      return 8'hFF;
    end
    return wide[7:0];
  endfunction

  // Synchronizer chain; free-running, not reset, so it keeps flushing during reset.
  always_ff @(posedge clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], delayed_clk};
  end

  assign w_s         = r_sync[SYNC_STAGES-1];
  assign w_start_acc = (r_state == ST_IDLE) && start;

  // Next-state decode; start and ack only matter in their own states.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_phase_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (r_phase_cnt == WIN_LAST) begin
          w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (result_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus status flags decoded from the next state so they are registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_MEASURE);
      r_valid <= (w_state_nxt == ST_DONE);
    end
  end

  // Per-phase cycle counter; restarts whenever the state changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_phase_cnt <= '0;
    end else if ((r_state == ST_SETTLE) || (r_state == ST_MEASURE)) begin
      r_phase_cnt <= r_phase_cnt + CW'(1);
    end
  end

  // High-sample accumulator, cleared when a measurement is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ones <= '0;
    end else if (w_start_acc) begin
      r_ones <= '0;
    end else if (r_state == ST_MEASURE) begin
      r_ones <= r_ones + CW'(w_s);
    end
  end

  // Published ones result; only changes on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ones_count <= 8'd0;
    end else if (r_state == ST_LATCH) begin
      r_ones_count <= sat8(r_ones);
    end
  end

  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign ones_count   = r_ones_count;

`ifdef TDC_EDGE_COUNT_EN
  logic [CW-1:0] r_edges;
  logic          r_prev;
  logic          r_first;
  logic [7:0]    r_edge_count;

  // Transition counter; the first window sample has no predecessor so it never counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_edges <= '0;
      r_prev  <= 1'b0;
      r_first <= 1'b0;
    end else if (w_start_acc) begin
      r_edges <= '0;
      r_prev  <= 1'b0;
      r_first <= 1'b1;
    end else if (r_state == ST_MEASURE) begin
      r_prev  <= w_s;
      r_first <= 1'b0;
      if (!r_first && (w_s != r_prev)) begin
        r_edges <= r_edges + CW'(1);
      end
    end
  end

  // Published transition result; only changes on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_edge_count <= 8'd0;
    end else if (r_state == ST_LATCH) begin
      r_edge_count <= sat8(r_edges);
    end
  end

  assign edge_count = r_edge_count;
`else
  assign edge_count = 8'd0;
`endif

endmodule
